ctrl_seq: RTL and testbench

Control sequencer for the SAP-3 core. It consumes the instruction register output and the ALU flags, and steps through fetch and execute T-states. Each cycle it drives the control word that orchestrates the PC, MAR, memory, IR, A/B registers, ALU and output port on the shared 8-bit bus. It is the stage directly downstream of the instruction register. Its `ir_we` bit is what loads that register.

---
 rtl/sap3_pkg.sv | 84 ++++++++
 rtl/ctrl_tstate.sv | 33 +++
 rtl/ctrl_seq.sv | 113 +++++++++++
 tb/tb_ctrl_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sap3_pkg.sv
// Shared definitions for the SAP-3 control sequencer: control-word bit map,
// opcode constants and the T-state encoding.
package sap3_pkg;

  localparam int CW_W = 15;

  // Control word bit positions, LSB first.
  localparam int CB_PC_OE    = 0;
  localparam int CB_PC_INC   = 1;
  localparam int CB_PC_WE    = 2;
  localparam int CB_MAR_WE   = 3;
  localparam int CB_MEM_OE   = 4;
  localparam int CB_MEM_WE   = 5;
  localparam int CB_IR_WE    = 6;
  localparam int CB_A_WE     = 7;
  localparam int CB_A_OE     = 8;
  localparam int CB_B_WE     = 9;
  localparam int CB_B_OE     = 10;
  localparam int CB_ALU_OE   = 11;
  localparam int CB_ALU_SUB  = 12;
  localparam int CB_FLAGS_WE = 13;
  localparam int CB_OUT_WE   = 14;

  localparam logic [CW_W-1:0] CW_PC_OE    = CW_W'(1) << CB_PC_OE;
  localparam logic [CW_W-1:0] CW_PC_INC   = CW_W'(1) << CB_PC_INC;
  localparam logic [CW_W-1:0] CW_PC_WE    = CW_W'(1) << CB_PC_WE;
  localparam logic [CW_W-1:0] CW_MAR_WE   = CW_W'(1) << CB_MAR_WE;
  localparam logic [CW_W-1:0] CW_MEM_OE   = CW_W'(1) << CB_MEM_OE;
  localparam logic [CW_W-1:0] CW_MEM_WE   = CW_W'(1) << CB_MEM_WE;
  localparam logic [CW_W-1:0] CW_IR_WE    = CW_W'(1) << CB_IR_WE;
  localparam logic [CW_W-1:0] CW_A_WE     = CW_W'(1) << CB_A_WE;
  localparam logic [CW_W-1:0] CW_A_OE     = CW_W'(1) << CB_A_OE;
  localparam logic [CW_W-1:0] CW_B_WE     = CW_W'(1) << CB_B_WE;
  localparam logic [CW_W-1:0] CW_B_OE     = CW_W'(1) << CB_B_OE;
  localparam logic [CW_W-1:0] CW_ALU_OE   = CW_W'(1) << CB_ALU_OE;
  localparam logic [CW_W-1:0] CW_ALU_SUB  = CW_W'(1) << CB_ALU_SUB;
  localparam logic [CW_W-1:0] CW_FLAGS_WE = CW_W'(1) << CB_FLAGS_WE;
  localparam logic [CW_W-1:0] CW_OUT_WE   = CW_W'(1) << CB_OUT_WE;

  // Frequently used composite words.
  localparam logic [CW_W-1:0] CW_ADDR_PH = CW_PC_OE | CW_MAR_WE;
  localparam logic [CW_W-1:0] CW_FETCH_1 = CW_MEM_OE | CW_IR_WE | CW_PC_INC;
  localparam logic [CW_W-1:0] CW_ALU_ADD = CW_ALU_OE | CW_A_WE | CW_FLAGS_WE;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_MVI = 8'h3E;
  localparam logic [7:0] OP_LDA = 8'h3A;
  localparam logic [7:0] OP_STA = 8'h32;
  localparam logic [7:0] OP_ADD = 8'h80;
  localparam logic [7:0] OP_SUB = 8'h90;
  localparam logic [7:0] OP_MOV = 8'h47;
  localparam logic [7:0] OP_OUT = 8'hD3;
  localparam logic [7:0] OP_JMP = 8'hC3;
  localparam logic [7:0] OP_JZ  = 8'hCA;
  localparam logic [7:0] OP_JC  = 8'hDA;
  localparam logic [7:0] OP_HLT = 8'h76;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    HALT = 3'd6
  } tstate_e;

  function automatic tstate_e next_tstate(input tstate_e cur);
    tstate_e nxt;
    nxt = T0;
    case (cur)
      T0:      nxt = T1;
      T1:      nxt = T2;
      T2:      nxt = T3;
      T3:      nxt = T4;
      T4:      nxt = T5;
      T5:      nxt = T0;
      HALT:    nxt = HALT;
      default: nxt = T0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_tstate.sv
// T-state register: advances one state per step, returns to T0 when the
// current instruction is done, and parks in HALT until reset.
module ctrl_tstate
  import sap3_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    step_i,
  input  logic    done_i,
  input  logic    halt_i,
  output tstate_e state_o
);

  tstate_e state_q;

  // HALT is sticky; only the asynchronous reset leaves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= T0;
    end else if (state_q == HALT) begin
      state_q <= HALT;
    end else if (halt_i) begin
      state_q <= HALT;
    end else if (done_i) begin
      state_q <= T0;
    end else if (step_i) begin
      state_q <= next_tstate(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/ctrl_seq.sv
// SAP-3 control sequencer: decodes T-state and opcode into the control word.
// Conditional jumps JZ/JC are honoured only when SAP3_CTRL_COND_JMP_EN is defined.
module ctrl_seq
  import sap3_pkg::*;
#(
  parameter int CW_W = sap3_pkg::CW_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      ir,
  input  logic            flag_z,
  input  logic            flag_c,
  output logic [CW_W-1:0] ctrl,
  output logic [2:0]      tstate,
  output logic            halted
);

  if (CW_W != sap3_pkg::CW_W) begin : g_cw_check
    $error("ctrl_seq: CW_W must match sap3_pkg::CW_W");
  end

  tstate_e         state;
  logic [CW_W-1:0] word;
  logic            done;
  logic            halt;
  logic            taken;

  ctrl_tstate u_tstate (
    .clk    (clk),
    .rst    (rst),
    .step_i (1'b1),
    .done_i (done),
    .halt_i (halt),
    .state_o(state)
  );

`ifdef SAP3_CTRL_COND_JMP_EN
  // Flags are read live during T3 so a same-cycle flag update is honoured.
  assign taken = (ir == OP_JZ) ? flag_z : flag_c;
`else
  logic unused_flags;
  assign unused_flags = flag_z ^ flag_c;
  assign taken        = 1'b0;
`endif

  always_comb begin
    word = '0;
    done = 1'b0;
    halt = 1'b0;
    unique case (state)
      T0: word = CW_ADDR_PH;
      T1: word = CW_FETCH_1;
      T2: begin
        unique case (ir)
          OP_MVI, OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JC: word = CW_ADDR_PH;
          OP_ADD: begin
            word = CW_ALU_ADD;
            done = 1'b1;
          end
          OP_SUB: begin
            word = CW_ALU_ADD | CW_ALU_SUB;
            done = 1'b1;
          end
          OP_MOV: begin
            word = CW_A_OE | CW_B_WE;
            done = 1'b1;
          end
          OP_OUT: begin
            word = CW_A_OE | CW_OUT_WE;
            done = 1'b1;
          end
          OP_HLT:  halt = 1'b1;
          default: done = 1'b1;
        endcase
      end
      T3: begin
        unique case (ir)
          OP_MVI: begin
            word = CW_MEM_OE | CW_A_WE | CW_PC_INC;
            done = 1'b1;
          end
          OP_LDA, OP_STA: word = CW_MEM_OE | CW_MAR_WE | CW_PC_INC;
          OP_JMP: begin
            word = CW_MEM_OE | CW_PC_WE;
            done = 1'b1;
          end
          // Not-taken still steps PC past the address byte.
          OP_JZ, OP_JC: begin
            word = taken ? (CW_MEM_OE | CW_PC_WE) : CW_PC_INC;
            done = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T4: begin
        unique case (ir)
          OP_LDA:  word = CW_MEM_OE | CW_A_WE;
          OP_STA:  word = CW_A_OE | CW_MEM_WE;
          default: word = '0;
        endcase
        done = 1'b1;
      end
      T5:      done = 1'b1;
      HALT:    word = '0;
      default: done = 1'b1;
    endcase
  end

  assign ctrl   = rst ? '0 : word;
  assign halted = (state == HALT);
  assign tstate = (state == HALT) ? 3'd0 : state;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed instruction sequences with a
// queue-based scoreboard checked on the falling clock edge.
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ir;
  logic        fz;
  logic        fc;
  logic [14:0] ctrl;
  logic [2:0]  tstate;
  logic        halted;

  int errors = 0;
  int checks = 0;

  // Entry layout: {chk_tstate, halted, tstate[2:0], ctrl[14:0]}
  logic [19:0] exp_q[$];
  logic [7:0]  cur_ir;

`ifdef SAP3_CTRL_COND_JMP_EN
  localparam logic [14:0] JMP_TAKEN = 15'h0014;
`else
  localparam logic [14:0] JMP_TAKEN = 15'h0002;
`endif

  always #5 clk = ~clk;

  ctrl_seq #(.CW_W(15)) dut (
    .clk   (clk),
    .rst   (rst),
    .ir    (ir),
    .flag_z(fz),
    .flag_c(fc),
    .ctrl  (ctrl),
    .tstate(tstate),
    .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock cycle, compared mid-cycle.
  always @(negedge clk) begin
    logic [19:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctrl", {17'd0, ctrl}, {17'd0, e[14:0]});
      check("halted", {31'd0, halted}, {31'd0, e[18]});
      if (e[19]) check("tstate", {29'd0, tstate}, {29'd0, e[17:15]});
    end
  end

  // Drive one cycle starting just after a rising edge.
  task automatic step(input logic [7:0] op, input logic z, input logic c,
                      input logic [14:0] w, input logic [2:0] t,
                      input logic h, input logic ct);
    ir = op;
    fz = z;
    fc = c;
    exp_q.push_back({ct, h, t, w});
    @(posedge clk);
    #1;
  endtask

  // IR still holds the previous opcode during fetch.
  task automatic fetch();
    step(cur_ir, 1'b0, 1'b0, 15'h0009, 3'd0, 1'b0, 1'b1);
    step(cur_ir, 1'b0, 1'b0, 15'h0052, 3'd1, 1'b0, 1'b1);
  endtask

  task automatic instr(input logic [7:0] op, input logic z, input logic c, input int n,
                       input logic [14:0] w2, input logic [14:0] w3, input logic [14:0] w4);
    fetch();
    cur_ir = op;
    step(op, z, c, w2, 3'd2, 1'b0, 1'b1);
    if (n > 1) step(op, z, c, w3, 3'd3, 1'b0, 1'b1);
    if (n > 2) step(op, z, c, w4, 3'd4, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {17'd0, ctrl}, 32'd0);
    check({tag, "_tstate"}, {29'd0, tstate}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    ir     = 8'h00;
    fz     = 1'b0;
    fc     = 1'b0;
    cur_ir = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    instr(8'h00, 1'b0, 1'b0, 1, 15'h0000, 15'h0000, 15'h0000);  // NOP
    instr(8'h3E, 1'b0, 1'b0, 2, 15'h0009, 15'h0092, 15'h0000);  // MVI A,n
    instr(8'h3A, 1'b0, 1'b0, 3, 15'h0009, 15'h001A, 15'h0090);  // LDA
    instr(8'h32, 1'b0, 1'b0, 3, 15'h0009, 15'h001A, 15'h0120);  // STA
    instr(8'h80, 1'b0, 1'b0, 1, 15'h2880, 15'h0000, 15'h0000);  // ADD B
    instr(8'h90, 1'b0, 1'b0, 1, 15'h3880, 15'h0000, 15'h0000);  // SUB B
    instr(8'h47, 1'b0, 1'b0, 1, 15'h0300, 15'h0000, 15'h0000);  // MOV B,A
    instr(8'hD3, 1'b0, 1'b0, 1, 15'h4100, 15'h0000, 15'h0000);  // OUT
    instr(8'hC3, 1'b0, 1'b0, 2, 15'h0009, 15'h0014, 15'h0000);  // JMP
    instr(8'hCA, 1'b1, 1'b0, 2, 15'h0009, JMP_TAKEN, 15'h0000); // JZ, Z=1
    instr(8'hCA, 1'b0, 1'b1, 2, 15'h0009, 15'h0002, 15'h0000);  // JZ, Z=0
    instr(8'hDA, 1'b0, 1'b1, 2, 15'h0009, JMP_TAKEN, 15'h0000); // JC, C=1
    instr(8'hDA, 1'b1, 1'b0, 2, 15'h0009, 15'h0002, 15'h0000);  // JC, C=0
    instr(8'hFF, 1'b0, 1'b0, 1, 15'h0000, 15'h0000, 15'h0000);  // undefined

    // JZ whose flag rises partway through T3.
    fetch();
    cur_ir = 8'hCA;
    step(8'hCA, 1'b0, 1'b0, 15'h0009, 3'd2, 1'b0, 1'b1);
    ir = 8'hCA;
    fz = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 3'd3, JMP_TAKEN});
    #2 fz = 1'b1;
    @(posedge clk);
    #1;

    // Reset during LDA T3 aborts the instruction.
    fetch();
    cur_ir = 8'h3A;
    step(8'h3A, 1'b0, 1'b0, 15'h0009, 3'd2, 1'b0, 1'b1);
    ir = 8'h3A;
    fz = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 3'd3, 15'h001A});
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    check_reset_outputs("abort_hold");
    rst = 1'b0;
    instr(8'h00, 1'b0, 1'b0, 1, 15'h0000, 15'h0000, 15'h0000);

    // HLT, then stay halted for 10 cycles.
    fetch();
    cur_ir = 8'h76;
    step(8'h76, 1'b0, 1'b0, 15'h0000, 3'd2, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(8'h76, i[0], i[1], 15'h0000, 3'd0, 1'b1, 1'b0);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("halt_rst");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cur_ir = 8'h00;
    instr(8'h00, 1'b0, 1'b0, 1, 15'h0000, 15'h0000, 15'h0000);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
